// File: rtl/opcode_encoder_queue.sv
// One-hot ALU opcode request -> 4-bit select encoder feeding a small FWFT FIFO.
// Malformed requests (zero or several bits set) are dropped and counted.
module opcode_encoder_queue #(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [11:0]              in_onehot,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [3:0]               out_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_pulse,
  output logic [ERR_W-1:0]         err_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [3:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [3:0]    enc;
  logic          onehot_ok;
  logic          fire_in, push, pop;

  // Any pattern outside the twelve legal one-hot words is rejected.
  always_comb begin
    enc       = 4'h0;
    onehot_ok = 1'b1;
    case (in_onehot)
      12'h001: enc = 4'b0000;
      12'h002: enc = 4'b0001;
      12'h004: enc = 4'b0010;
      12'h008: enc = 4'b0011;
      12'h010: enc = 4'b0100;
      12'h020: enc = 4'b0101;
      12'h040: enc = 4'b0110;
      12'h080: enc = 4'b1000;
      12'h100: enc = 4'b1001;
      12'h200: enc = 4'b1010;
      12'h400: enc = 4'b1011;
      12'h800: enc = 4'b1111;
      default: onehot_ok = 1'b0;
    endcase
  end

  // Full/empty come from the occupancy count, so the handshakes never see in_*.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_sel   = mem[rd_ptr];

  assign fire_in = in_valid & in_ready;
  assign push    = fire_in & onehot_ok;
  assign pop     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 4'h0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= enc;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      err_pulse <= fire_in & ~onehot_ok;
      if (fire_in && !onehot_ok && err_count != '1)
        err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_opcode_encoder_queue.sv
// Directed + randomized bench for opcode_encoder_queue, checked against a
// queue-based reference model with immediate assertions.
module tb_opcode_encoder_queue;

  localparam int DEPTH = 4;
  localparam int ERR_W = 8;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] in_onehot = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  out_sel;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  count;
  logic        err_pulse;
  logic [ERR_W-1:0] err_count;

  int total = 0;
  int bad = 0;

  logic [3:0] q[$];
  int         errc = 0;
  bit         errp = 0;

  opcode_encoder_queue #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_onehot(in_onehot), .in_valid(in_valid), .in_ready(in_ready),
    .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Table lookup from the opcode list: bit position -> select code.
  function automatic logic [3:0] enc_ref(input logic [11:0] v);
    int idx = 0;
    for (int i = 0; i < 12; i++) if (v[i]) idx = i;
    if (idx == 11) return 4'hF;
    if (idx >= 7)  return 4'(idx + 1);
    return 4'(idx);
  endfunction

  function automatic logic [11:0] rand_bad();
    logic [11:0] r;
    r = 12'($urandom);
    if ($countones(r) == 1) r = ($urandom_range(0, 1) == 0) ? 12'h000 : (r | (r == 12'h001 ? 12'h002 : 12'h001));
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, 32'(count), 32'(q.size()));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < DEPTH));
    check({tag, ".err_pulse"}, 32'(err_pulse), 32'(errp));
    check({tag, ".err_count"}, 32'(err_count), 32'(errc));
    if (q.size() > 0) check({tag, ".out_sel"}, 32'(out_sel), 32'(q[0]));
  endtask

  // One clock: drive inputs, advance the model across the edge, check #1 later.
  task automatic step(input string tag, input logic [11:0] oh, input logic v,
                      input logic ordy, input logic rst = 1'b1);
    bit fin, pop;
    logic [3:0] dummy;
    rst_n = rst; in_onehot = oh; in_valid = v; out_ready = ordy;
    fin = v && (q.size() < DEPTH);
    pop = (q.size() > 0) && ordy;
    @(posedge clk);
    if (!rst) begin
      q.delete(); errc = 0; errp = 0;
    end else begin
      errp = 0;
      if (pop) dummy = q.pop_front();
      if (fin) begin
        if ($countones(oh) == 1) q.push_back(enc_ref(oh));
        else begin
          errp = 1;
          if (errc < ERR_MAX) errc++;
        end
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [11:0] w;
    // reset
    step("rst0", 12'h000, 1'b0, 1'b0, 1'b0);
    step("rst1", 12'h000, 1'b0, 1'b0, 1'b0);
    check("rst.out_sel", 32'(out_sel), 32'h0);

    // 1: three pushes with consumer ready, 1-cycle latency each
    step("t1a", 12'h001, 1'b1, 1'b1);
    check("t1a.sel", 32'(out_sel), 32'h0);
    step("t1b", 12'h080, 1'b1, 1'b1);
    check("t1b.sel", 32'(out_sel), 32'h8);
    step("t1c", 12'h800, 1'b1, 1'b1);
    check("t1c.sel", 32'(out_sel), 32'hF);
    step("t1d", 12'h000, 1'b0, 1'b1);

    // 2: fill with consumer stalled; fifth request refused, then drain
    step("t2a", 12'h002, 1'b1, 1'b0);
    step("t2b", 12'h004, 1'b1, 1'b0);
    step("t2c", 12'h100, 1'b1, 1'b0);
    step("t2d", 12'h400, 1'b1, 1'b0);
    check("t2.full_ready", 32'(in_ready), 32'h0);
    check("t2.full_count", 32'(count), 32'd4);
    step("t2e", 12'h200, 1'b1, 1'b0);
    check("t2e.hold_sel", 32'(out_sel), 32'h1);
    for (int i = 0; i < 5; i++) step("t2drain", 12'h000, 1'b0, 1'b1);
    check("t2.empty", 32'(count), 32'd0);

    // 3: malformed requests
    step("t3a", 12'h000, 1'b1, 1'b0);
    check("t3a.pulse", 32'(err_pulse), 32'h1);
    step("t3b", 12'h003, 1'b1, 1'b0);
    step("t3c", 12'h000, 1'b0, 1'b0);
    check("t3.pulse_low", 32'(err_pulse), 32'h0);
    check("t3.errcnt", 32'(err_count), 32'd2);

    // 4: simultaneous push/pop at count=2, then wrap
    step("t4a", 12'h008, 1'b1, 1'b0);
    step("t4b", 12'h010, 1'b1, 1'b0);
    step("t4pp", 12'h020, 1'b1, 1'b1);
    check("t4.count2", 32'(count), 32'd2);
    for (int i = 0; i < 8; i++) begin
      w = 12'h001 << $urandom_range(0, 11);
      step("t4wrap", w, 1'b1, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 6; i++) step("t4drain", 12'h000, 1'b0, 1'b1);

    // 5: saturate the error counter
    for (int i = 0; i < 260; i++) step("t5", rand_bad(), 1'b1, 1'b1);
    check("t5.sat", 32'(err_count), 32'd255);

    // random mix
    for (int i = 0; i < 300; i++) begin
      w = ($urandom_range(0, 3) == 0) ? rand_bad() : (12'h001 << $urandom_range(0, 11));
      step("rnd", w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 6; i++) step("rnd_drain", 12'h000, 1'b0, 1'b1);

    // 6: reset with three queued entries and an in-flight request
    step("t6a", 12'h040, 1'b1, 1'b0);
    step("t6b", 12'h001, 1'b1, 1'b0);
    step("t6c", 12'h800, 1'b1, 1'b0);
    check("t6.count3", 32'(count), 32'd3);
    step("t6rst", 12'h002, 1'b1, 1'b0, 1'b0);
    check("t6.count0", 32'(count), 32'd0);
    check("t6.valid0", 32'(out_valid), 32'h0);
    check("t6.err0", 32'(err_count), 32'h0);
    check("t6.ready1", 32'(in_ready), 32'h1);
    step("t6post", 12'h100, 1'b1, 1'b1);
    check("t6post.sel", 32'(out_sel), 32'h9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
